// File: rtl/arcade_input_pkg.sv
// Shared constants for arcade_input_cond: PS/2 scancodes, joystick bit map,
// held-key indices and the coin FSM state type.
package arcade_input_pkg;

  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_F1     = 8'h05;
  localparam logic [7:0] SC_1      = 8'h16;
  localparam logic [7:0] SC_F2     = 8'h06;
  localparam logic [7:0] SC_2      = 8'h1E;
  localparam logic [7:0] SC_5      = 8'h2E;
  localparam logic [7:0] SC_6      = 8'h36;
  localparam logic [7:0] SC_R      = 8'h2D;
  localparam logic [7:0] SC_F      = 8'h2B;
  localparam logic [7:0] SC_D      = 8'h23;
  localparam logic [7:0] SC_G      = 8'h34;
  localparam logic [7:0] SC_A      = 8'h1C;

  localparam int JOY_RIGHT  = 0;
  localparam int JOY_LEFT   = 1;
  localparam int JOY_DOWN   = 2;
  localparam int JOY_UP     = 3;
  localparam int JOY_FIRE   = 4;
  localparam int JOY_START1 = 5;
  localparam int JOY_START2 = 6;
  localparam int JOY_COIN   = 7;

  // One held-key bit per physical key, so two keys sharing a control stay independent
  localparam int K_UP      = 0;
  localparam int K_DOWN    = 1;
  localparam int K_LEFT    = 2;
  localparam int K_RIGHT   = 3;
  localparam int K_FIRE_A  = 4;
  localparam int K_FIRE_B  = 5;
  localparam int K_START1A = 6;
  localparam int K_START1B = 7;
  localparam int K_START2A = 8;
  localparam int K_START2B = 9;
  localparam int K_COIN_A  = 10;
  localparam int K_COIN_B  = 11;
  localparam int K_UP2     = 12;
  localparam int K_DOWN2   = 13;
  localparam int K_LEFT2   = 14;
  localparam int K_RIGHT2  = 15;
  localparam int K_FIRE2   = 16;
  localparam int KEY_NUM   = 17;

  typedef enum logic [1:0] {
    COIN_IDLE,
    COIN_PULSE,
    COIN_GAP,
    COIN_WAIT_REL
  } coin_state_t;

  function automatic logic [KEY_NUM-1:0] key_match(input logic ext, input logic [7:0] code);
    logic [KEY_NUM-1:0] m;
    m = '0;
    case (code)
      SC_UP:    m[K_UP]    = 1'b1;
      SC_DOWN:  m[K_DOWN]  = 1'b1;
      SC_LEFT:  m[K_LEFT]  = 1'b1;
      SC_RIGHT: m[K_RIGHT] = 1'b1;
      default:  ;
    endcase
    if (!ext) begin
      case (code)
        SC_SPACE: m[K_FIRE_A]  = 1'b1;
        SC_CTRL:  m[K_FIRE_B]  = 1'b1;
        SC_F1:    m[K_START1A] = 1'b1;
        SC_1:     m[K_START1B] = 1'b1;
        SC_F2:    m[K_START2A] = 1'b1;
        SC_2:     m[K_START2B] = 1'b1;
        SC_5:     m[K_COIN_A]  = 1'b1;
        SC_6:     m[K_COIN_B]  = 1'b1;
        SC_R:     m[K_UP2]     = 1'b1;
        SC_F:     m[K_DOWN2]   = 1'b1;
        SC_D:     m[K_LEFT2]   = 1'b1;
        SC_G:     m[K_RIGHT2]  = 1'b1;
        SC_A:     m[K_FIRE2]   = 1'b1;
        default:  ;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/coin_pulse_fsm.sv
// Shapes a level coin request into one fixed-width pulse followed by a forced gap;
// a new credit needs the request to drop after the gap.
//
// state    | meaning
// IDLE     | armed, waiting for a request
// PULSE    | coin high for COIN_PULSE_CYCLES
// GAP      | coin forced low for COIN_GAP_CYCLES
// WAIT_REL | waiting for the request to drop (also the reset state)
module coin_pulse_fsm #(
  parameter int COIN_PULSE_CYCLES = 1_800_000,
  parameter int COIN_GAP_CYCLES   = 1_800_000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic req,
  output logic coin
);
  import arcade_input_pkg::*;

  localparam logic [23:0] PULSE_LAST = 24'(COIN_PULSE_CYCLES - 1);
  localparam logic [23:0] GAP_LAST   = 24'(COIN_GAP_CYCLES - 1);

  coin_state_t state, state_nxt;
  logic [23:0] cnt;
  logic        coin_nxt;

  // Counter restarts on every state entry and saturates instead of wrapping
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= COIN_WAIT_REL;
      cnt   <= '0;
      coin  <= 1'b0;
    end else begin
      state <= state_nxt;
      coin  <= coin_nxt;
      if (state_nxt != state) cnt <= '0;
      else if (cnt != 24'hFF_FFFF) cnt <= cnt + 24'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COIN_IDLE:     if (req) state_nxt = COIN_PULSE;
      COIN_PULSE:    if (cnt == PULSE_LAST) state_nxt = COIN_GAP;
      COIN_GAP:      if (cnt == GAP_LAST) state_nxt = COIN_WAIT_REL;
      COIN_WAIT_REL: if (!req) state_nxt = COIN_IDLE;
      default:       state_nxt = COIN_WAIT_REL;
    endcase
  end

  always_comb begin
    coin_nxt = (state == COIN_PULSE);
  end

endmodule

// File: rtl/arcade_input_cond.sv
// PS/2 + joystick input conditioner for the galaga core: key decode, rotation remap,
// coin shaping. Optional autofire is built when ARCADE_INPUT_AUTOFIRE_EN is defined.
module arcade_input_cond #(
  parameter int COIN_PULSE_CYCLES = 1_800_000,
  parameter int COIN_GAP_CYCLES   = 1_800_000,
  parameter int AUTOFIRE_DIV      = 600_000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy,
  input  logic        no_rotate,
  input  logic        autofire_en,
  output logic        p1_left,
  output logic        p1_right,
  output logic        p1_fire,
  output logic        p2_left,
  output logic        p2_right,
  output logic        p2_fire,
  output logic        start1,
  output logic        start2,
  output logic        coin
);
  import arcade_input_pkg::*;

  logic               prev_tog;
  logic [KEY_NUM-1:0] key_q;
  logic [KEY_NUM-1:0] hit;
  logic [7:0]         joy_q;
  logic               key_evt;

  assign key_evt = (ps2_key[10] != prev_tog);
  assign hit     = key_match(ps2_key[8], ps2_key[7:0]);

  // joy keeps sampling through reset so a coin held across reset looks held afterwards
  always_ff @(posedge clk_sys) begin
    prev_tog <= ps2_key[10];
    joy_q    <= joy[7:0];
    if (reset) key_q <= '0;
    else if (key_evt) key_q <= (key_q & ~hit) | (hit & {KEY_NUM{ps2_key[9]}});
  end

  logic l1_src, r1_src, l2_src, r2_src;
  logic f1_held, f2_held, s1_src, s2_src, coin_req;
  logic f1_out, f2_out;

  always_comb begin
    if (no_rotate) begin
      l1_src = key_q[K_DOWN]  | joy_q[JOY_DOWN];
      r1_src = key_q[K_UP]    | joy_q[JOY_UP];
      l2_src = key_q[K_DOWN2] | joy_q[JOY_DOWN];
      r2_src = key_q[K_UP2]   | joy_q[JOY_UP];
    end else begin
      l1_src = key_q[K_LEFT]   | joy_q[JOY_LEFT];
      r1_src = key_q[K_RIGHT]  | joy_q[JOY_RIGHT];
      l2_src = key_q[K_LEFT2]  | joy_q[JOY_LEFT];
      r2_src = key_q[K_RIGHT2] | joy_q[JOY_RIGHT];
    end
    f1_held  = key_q[K_FIRE_A] | key_q[K_FIRE_B] | joy_q[JOY_FIRE];
    f2_held  = key_q[K_FIRE2] | joy_q[JOY_FIRE];
    s1_src   = key_q[K_START1A] | key_q[K_START1B] | joy_q[JOY_START1];
    s2_src   = key_q[K_START2A] | key_q[K_START2B] | joy_q[JOY_START2];
    coin_req = key_q[K_COIN_A] | key_q[K_COIN_B] | joy_q[JOY_COIN];
  end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
  localparam logic [23:0] AF_LAST = 24'(AUTOFIRE_DIV - 1);

  logic [1:0][23:0] af_cnt;
  logic [1:0]       af_phase;
  logic [1:0]       fire_held;
  logic             unused_in;

  assign fire_held = {f2_held, f1_held};
  assign unused_in = ^joy[15:8];

  // Each player's phase starts high on press and is rearmed on release
  always_ff @(posedge clk_sys) begin
    for (int p = 0; p < 2; p++) begin
      if (reset || !fire_held[p]) begin
        af_cnt[p]   <= '0;
        af_phase[p] <= 1'b1;
      end else if (af_cnt[p] == AF_LAST) begin
        af_cnt[p]   <= '0;
        af_phase[p] <= ~af_phase[p];
      end else begin
        af_cnt[p] <= af_cnt[p] + 24'd1;
      end
    end
  end

  assign f1_out = f1_held & (~autofire_en | af_phase[0]);
  assign f2_out = f2_held & (~autofire_en | af_phase[1]);
`else
  logic unused_in;

  assign unused_in = ^{joy[15:8], autofire_en, AUTOFIRE_DIV[0]};
  assign f1_out    = f1_held;
  assign f2_out    = f2_held;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      p1_left  <= 1'b0;
      p1_right <= 1'b0;
      p1_fire  <= 1'b0;
      p2_left  <= 1'b0;
      p2_right <= 1'b0;
      p2_fire  <= 1'b0;
      start1   <= 1'b0;
      start2   <= 1'b0;
    end else begin
      p1_left  <= l1_src;
      p1_right <= r1_src;
      p1_fire  <= f1_out;
      p2_left  <= l2_src;
      p2_right <= r2_src;
      p2_fire  <= f2_out;
      start1   <= s1_src;
      start2   <= s2_src;
    end
  end

  coin_pulse_fsm #(
    .COIN_PULSE_CYCLES(COIN_PULSE_CYCLES),
    .COIN_GAP_CYCLES  (COIN_GAP_CYCLES)
  ) u_coin (
    .clk_sys(clk_sys),
    .reset  (reset),
    .req    (coin_req),
    .coin   (coin)
  );

endmodule

// File: tb/tb_arcade_input_cond.sv
// Bench for arcade_input_cond: directed scenarios then random PS/2/joy traffic,
// every cycle compared against a behavioural model of held keys and coin timeline.
module tb_arcade_input_cond;
  localparam int P   = 4;
  localparam int G   = 3;
  localparam int DIV = 5;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [15:0] joy;
  logic        no_rotate;
  logic        autofire_en;
  logic        p1_left, p1_right, p1_fire, p2_left, p2_right, p2_fire;
  logic        start1, start2, coin;

  always #5 clk_sys = ~clk_sys;

  arcade_input_cond #(
    .COIN_PULSE_CYCLES(P),
    .COIN_GAP_CYCLES  (G),
    .AUTOFIRE_DIV     (DIV)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_key    (ps2_key),
    .joy        (joy),
    .no_rotate  (no_rotate),
    .autofire_en(autofire_en),
    .p1_left    (p1_left),
    .p1_right   (p1_right),
    .p1_fire    (p1_fire),
    .p2_left    (p2_left),
    .p2_right   (p2_right),
    .p2_fire    (p2_fire),
    .start1     (start1),
    .start2     (start2),
    .coin       (coin)
  );

  int errors = 0;
  int checks = 0;

  // Model: held level per {ext,scancode}; arrows are folded onto ext=0
  bit          held [512];
  logic [15:0] m_joy = '0;
  int          n_edge = 0;
  int          acc_edge = -1000;
  int          rel_from = 0;
  bit          released = 1'b0;
  int          af_c1 = 0, af_c2 = 0;
  logic        last_coin = 1'b0;
  int          rises = 0, highs = 0;
  logic [29:0] fire_trace;
  int          fire_idx = 0;

  function automatic bit h(input logic [7:0] c);
    return held[{1'b0, c}];
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, n_edge, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit flip, input bit pr, input bit ex, input logic [7:0] code);
    bit e_l1, e_r1, e_l2, e_r2, e_f1, e_f2, e_s1, e_s2, e_coin, req, hf1, hf2;
    reset = rst;
    if (flip) ps2_key = {~ps2_key[10], pr, ex, code};
    n_edge++;

    hf1  = h(8'h29) | h(8'h14) | m_joy[4];
    hf2  = h(8'h1C) | m_joy[4];
    e_l1 = no_rotate ? (h(8'h72) | m_joy[2]) : (h(8'h6B) | m_joy[1]);
    e_r1 = no_rotate ? (h(8'h75) | m_joy[3]) : (h(8'h74) | m_joy[0]);
    e_l2 = no_rotate ? (h(8'h2B) | m_joy[2]) : (h(8'h23) | m_joy[1]);
    e_r2 = no_rotate ? (h(8'h2D) | m_joy[3]) : (h(8'h34) | m_joy[0]);
    e_s1 = h(8'h05) | h(8'h16) | m_joy[5];
    e_s2 = h(8'h06) | h(8'h1E) | m_joy[6];
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    e_f1 = hf1 & (!autofire_en | (((af_c1 / DIV) % 2) == 0));
    e_f2 = hf2 & (!autofire_en | (((af_c2 / DIV) % 2) == 0));
`else
    e_f1 = hf1;
    e_f2 = hf2;
`endif
    req = h(8'h2E) | h(8'h36) | m_joy[7];

    // Coin timeline: an accepted press at edge a gives coin high on edges a+1..a+P
    if (rst) begin
      acc_edge = -1000;
      rel_from = n_edge + 1;
      released = 1'b0;
    end else if (released && req) begin
      acc_edge = n_edge;
      released = 1'b0;
      rel_from = n_edge + P + G + 1;
    end else if (!released && n_edge >= rel_from && !req) begin
      released = 1'b1;
    end
    e_coin = (n_edge >= acc_edge + 1) && (n_edge <= acc_edge + P);

    if (rst) {e_l1, e_r1, e_l2, e_r2, e_f1, e_f2, e_s1, e_s2, e_coin} = '0;

    af_c1 = (rst || !hf1) ? 0 : af_c1 + 1;
    af_c2 = (rst || !hf2) ? 0 : af_c2 + 1;
    if (rst) begin
      foreach (held[i]) held[i] = 1'b0;
    end else if (flip) begin
      if (code inside {8'h75, 8'h72, 8'h6B, 8'h74}) held[{1'b0, code}] = pr;
      else held[{ex, code}] = pr;
    end
    m_joy = joy;

    @(posedge clk_sys);
    @(negedge clk_sys);
    chk("p1_left",  p1_left,  e_l1);
    chk("p1_right", p1_right, e_r1);
    chk("p1_fire",  p1_fire,  e_f1);
    chk("p2_left",  p2_left,  e_l2);
    chk("p2_right", p2_right, e_r2);
    chk("p2_fire",  p2_fire,  e_f2);
    chk("start1",   start1,   e_s1);
    chk("start2",   start2,   e_s2);
    chk("coin",     coin,     e_coin);

    highs += int'(coin);
    if (coin && !last_coin) rises++;
    last_coin = coin;
    if (fire_idx < 30) begin
      fire_trace[fire_idx] = p1_fire;
      fire_idx++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic key(input bit pr, input bit ex, input logic [7:0] code);
    step(1'b0, 1'b1, pr, ex, code);
  endtask

  logic [7:0]  codes [20] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h05, 8'h16, 8'h06, 8'h1E,
                              8'h2E, 8'h36, 8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1A, 8'h4D, 8'h29};
  logic [29:0] af_exp;

  initial begin
    ps2_key     = 11'h400;
    joy         = '0;
    no_rotate   = 1'b0;
    autofire_en = 1'b0;

    // Reset with toggle high, including a key event discarded by reset
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h6B);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(3);
    chk("reset_p1_left", p1_left, 1'b0);

    key(1'b1, 1'b0, 8'h6B);
    idle(1);
    chk("left_after_2", p1_left, 1'b1);
    idle(2);
    key(1'b0, 1'b0, 8'h6B);
    idle(3);

    // Extended up arrow, rotation switched mid-press, released as non-extended
    no_rotate = 1'b1;
    key(1'b1, 1'b1, 8'h75);
    idle(3);
    chk("rot_right", p1_right, 1'b1);
    no_rotate = 1'b0;
    idle(1);
    chk("unrot_right", p1_right, 1'b0);
    no_rotate = 1'b1;
    key(1'b0, 1'b0, 8'h75);
    idle(3);
    no_rotate = 1'b0;

    // Held joystick coin gives exactly one P-wide pulse; re-press gives another
    rises = 0; highs = 0;
    joy = 16'h0080;
    idle(50);
    chk_int("hold_rises", rises, 1);
    chk_int("hold_width", highs, P);
    joy = 16'h0000;
    idle(6);
    rises = 0;
    joy = 16'h0080;
    idle(12);
    chk_int("repress_rises", rises, 1);
    joy = 16'h0000;
    idle(8);

    // Short press, re-press inside the gap, then a press after re-arming
    rises = 0;
    key(1'b1, 1'b0, 8'h2E);
    key(1'b0, 1'b0, 8'h2E);
    idle(4);
    key(1'b1, 1'b0, 8'h36);
    key(1'b0, 1'b0, 8'h36);
    idle(4);
    key(1'b1, 1'b0, 8'h2E);
    idle(3);
    key(1'b0, 1'b0, 8'h2E);
    idle(10);
    chk_int("gap_rises", rises, 2);

    // Reset while the pulse is high and coin still held
    joy = 16'h0080;
    for (int i = 0; i < 10 && coin !== 1'b1; i++) idle(1);
    chk("coin_seen", coin, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("coin_rst_drop", coin, 1'b0);
    rises = 0;
    idle(20);
    chk_int("held_thru_rst", rises, 0);
    joy = 16'h0000;
    idle(3);
    joy = 16'h0080;
    idle(10);
    chk_int("after_rst_rises", rises, 1);
    joy = 16'h0000;
    idle(8);

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    autofire_en = 1'b1;
    key(1'b1, 1'b0, 8'h29);
    fire_idx = 0;
    idle(30);
    for (int i = 0; i < 30; i++) af_exp[i] = ((i / DIV) % 2) == 0;
    checks++;
    assert (fire_trace === af_exp) else begin
      errors++;
      $error("FAIL autofire_pattern observed=%b expected=%b", fire_trace, af_exp);
    end
    key(1'b0, 1'b0, 8'h29);
    autofire_en = 1'b0;
    idle(3);
`endif

    for (int i = 0; i < 2000; i++) begin
      logic rst_r, flip_r, pr_r, ex_r;
      logic [7:0] code_r;
      rst_r  = ($urandom_range(0, 199) == 0);
      flip_r = ($urandom_range(0, 2) == 0);
      pr_r   = $urandom_range(0, 1) == 1;
      ex_r   = ($urandom_range(0, 3) == 0);
      code_r = codes[$urandom_range(0, 19)];
      if ($urandom_range(0, 9) == 0) joy[7:0] = joy[7:0] ^ (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) joy[15:8] = 8'($urandom);
      if ($urandom_range(0, 29) == 0) no_rotate = ~no_rotate;
      if ($urandom_range(0, 49) == 0) autofire_en = ~autofire_en;
      step(rst_r, flip_r, pr_r, ex_r, code_r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arcade_input_cond.md
# arcade_input_cond

Input conditioner that sits directly upstream of the `galaga` core inside `emu`. It decodes PS/2 key events and merges the MiSTer joystick word. It then applies cabinet-rotation remapping and drives the core's player/start/coin inputs. Coin presses are shaped into a fixed-width, edge-triggered pulse with a mandatory gap, so a held coin key or joystick button credits exactly once.

## Interface
Parameters:
- `COIN_PULSE_CYCLES`, 1_800_000: coin high width in `clk_sys` cycles (100 ms at 18 MHz); valid range 1..2^24-1.
- `COIN_GAP_CYCLES`, 1_800_000: forced coin-low time after each pulse; valid range 1..2^24-1.
- `AUTOFIRE_DIV`, 600_000: autofire half-period in cycles; only used with the macro.

Ports (one clock; reset is synchronous and active-high):
- `clk_sys` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `ps2_key` in 11: [10] toggle, [9] pressed, [8] extended, [7:0] scancode.
- `joy` in 16: OR of both joysticks; bit 0 right, 1 left, 2 down, 3 up, 4 fire, 5 start1, 6 start2, 7 coin.
- `no_rotate` in 1: 1 = horizontal orientation; remaps directions.
- `autofire_en` in 1: enables autofire; ignored without the macro.
- `p1_left`, `p1_right`, `p1_fire` out 1 each: player 1 controls.
- `p2_left`, `p2_right`, `p2_fire` out 1 each: player 2 controls.
- `start1`, `start2` out 1 each: start buttons.
- `coin` out 1: shaped coin pulse.

## Operation
- Event detection:
  - `prev_tog` is a register holding the previous `ps2_key[10]`.
  - An event occurs when `ps2_key[10] != prev_tog`.
  - On reset, `prev_tog` loads the current `ps2_key[10]`, so reset never generates a spurious event.
- On an event, the matching held-key register takes the value of `ps2_key[9]`. Unmatched codes are ignored.
- Arrow keys match regardless of the extended bit:
  - x75 up, x72 down, x6B left, x74 right.
- All other keys require extended = 0:
  - 029 and 014: fire1.
  - 005 and 016: start1.
  - 006 and 01E: start2.
  - 02E and 036: coin.
  - 02D up2, 02B down2, 023 left2, 034 right2, 01C fire2.
- `joy` is registered in the same stage as the key registers.
- Direction merge with `no_rotate = 0`:
  - left = key_left | joy[1].
  - right = key_right | joy[0].
- Direction merge with `no_rotate = 1`:
  - left = key_down | joy[2].
  - right = key_up | joy[3].
- Player 2 uses the same rule with the R/F/D/G keys.
- Fire and start: fireN = key_fireN | joy[4]; start1 = keys | joy[5]; start2 = keys | joy[6].
- `coin_req` = coin key 5 | coin key 6 | joy[7]. Start buttons never request coin.
- Coin FSM states: IDLE, PULSE, GAP, WAIT_REL.
  - IDLE → PULSE when `coin_req` = 1.
  - PULSE → GAP after `COIN_PULSE_CYCLES` cycles.
  - GAP → WAIT_REL after `COIN_GAP_CYCLES` cycles.
  - WAIT_REL → IDLE when `coin_req` = 0.
- `coin` = 1 only in PULSE.
- Changes to `coin_req` during PULSE or GAP are ignored. One press, however long, gives one pulse.
- Reset puts the FSM in WAIT_REL, so a coin held through reset is not credited.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Latency for a key event or `joy` change:
  - edge 1 captures it into the held-key/joy registers;
  - edge 2 updates the outputs.
  - Total: 2 cycles.
- `no_rotate` is combinational into the output stage, so it has 1 cycle latency. Changing it mid-press switches the source on the next edge.
- Coin timing:
  - `coin` rises 2 edges after `coin_req` becomes visible.
  - It is high for exactly `COIN_PULSE_CYCLES` cycles.
  - It is then low for at least `COIN_GAP_CYCLES` cycles.
- Cycle counter is 24 bits. It clears on every state entry and never wraps.
- Reset mid-pulse: `coin` drops on the next edge.
- Simultaneous events:
  - Only one PS/2 event per cycle is possible.
  - A joystick and key asserting the same control are ORed, with no conflict.
  - A key event in the same cycle as reset is discarded.

## Configuration
Macro: `ARCADE_INPUT_AUTOFIRE_EN`.
- Defined:
  - While fire (p1 or p2) is held and `autofire_en` = 1, the output is the held fire AND a phase bit.
  - Each player has its own phase and counter.
  - On press, phase is 1. It toggles every `AUTOFIRE_DIV` cycles.
  - On release, phase resets to 1 and the counter resets to 0.
- Not defined:
  - No autofire logic is built and `autofire_en` is unused.
  - Fire outputs equal the held fire.

## Structure
- Package `arcade_input_pkg`:
  - scancode localparams;
  - `joy` bit-index constants;
  - coin FSM state enum (`coin_state_t`).
- Sub-module `coin_pulse_fsm`:
  - ports: clk_sys, reset, req, coin;
  - parameterized by the two cycle counts.
- Top level holds the event detection, key registers, remap and the optional autofire.

## Test plan
- Reset with `ps2_key[10]` = 1: no event; all outputs 0. Toggle with pressed=1, code 0x06B → `p1_left` = 1 two edges later; toggle with pressed=0 → `p1_left` = 0.
- Arrow code 0x075 with extended = 1, `no_rotate` = 1 → `p1_right` = 1; set `no_rotate` = 0 → `p1_right` = 0 on the next edge.
- `COIN_PULSE_CYCLES` = 4, `COIN_GAP_CYCLES` = 3; hold joy[7] for 50 cycles → exactly one coin pulse, 4 cycles wide; release then press again → second pulse.
- Coin pressed, released after 1 cycle, pressed again during GAP → no extra pulse; pressed again after WAIT_REL → pulse.
- Assert reset while `coin` = 1 and coin held → `coin` = 0 next edge; no pulse until release and re-press.
- With macro, `AUTOFIRE_DIV` = 5, `autofire_en` = 1, space held 30 cycles → `p1_fire` pattern 5 high / 5 low, starting high.
